// File: rtl/msg_schedule_gen_if.sv
// ----------------------------------------------------------------------------
// msg_schedule_gen_if
//   Groups the block-input and word-output handshakes of msg_schedule_gen.
//
//   Valid/ready semantics (both channels): a transfer happens on a rising CLK
//   edge where valid and ready are both high. A source that has raised valid
//   holds valid and its payload stable until that transfer. Ready may depend
//   combinationally on the other channel's ready. Valid never depends on ready.
//
//   Parameters:
//     WORD_W   schedule word width (32 or 64)
//     ROUND_W  width of round_out
//
//   Signals:
//     blk_valid_in   block presented by the padding unit
//     blk_ready_out  generator can take a block this cycle
//     blk_in         16 words, W0 in the MSBs
//     w_valid_out    w_out holds a valid schedule word
//     w_ready_in     round core accepts the word this cycle
//     w_out          schedule word Wt
//     round_out      index t of the word on w_out
//     last_out       high with w_valid_out on the final word of a block
//
//   Modports:
//     master  the schedule generator side
//     slave   the environment (padding unit + round core)
// ----------------------------------------------------------------------------
interface msg_schedule_gen_if #(
  parameter int WORD_W  = 32,
  parameter int ROUND_W = 7
);
  logic                  blk_valid_in;
  logic                  blk_ready_out;
  logic [16*WORD_W-1:0]  blk_in;
  logic                  w_valid_out;
  logic                  w_ready_in;
  logic [WORD_W-1:0]     w_out;
  logic [ROUND_W-1:0]    round_out;
  logic                  last_out;

  modport master (
    input  blk_valid_in, blk_in, w_ready_in,
    output blk_ready_out, w_valid_out, w_out, round_out, last_out
  );

  modport slave (
    output blk_valid_in, blk_in, w_ready_in,
    input  blk_ready_out, w_valid_out, w_out, round_out, last_out
  );
endinterface

// File: rtl/msg_schedule_gen.sv
// ----------------------------------------------------------------------------
// msg_schedule_gen
//   SHA-2 message schedule generator. Loads one 16-word block and streams
//   W0..W(ROUNDS-1) to the compression core through a 16-entry shift
//   register. WORD_W=32 covers SHA-224/256, WORD_W=64 covers SHA-384/512.
//   Downstream stalls hold all state; a new block may be loaded in the same
//   cycle the last word leaves, so back-to-back blocks have no bubble.
//
//   Parameters:
//     WORD_W   32 or 64 (anything else stops elaboration)
//     ROUNDS   words emitted per block, 16..2**ROUND_W
//     ROUND_W  width of round_out
//
//   Ports:
//     CLK            clock, rising edge
//     RST            synchronous reset, active low
//     abort_in       synchronous flush to IDLE (beats a simultaneous load)
//     bus            msg_schedule_gen_if.master: block in / word out channels
//     state_out      FSM state (0=IDLE, 1=RUN)
//     stall_cnt_out  only with MSG_SCHED_STALL_CNT_EN: saturating count of
//                    cycles with w_valid_out && !w_ready_in, reset-only clear
//
//   Optional feature macro: MSG_SCHED_STALL_CNT_EN
// ----------------------------------------------------------------------------
module msg_schedule_gen #(
  parameter int WORD_W  = 32,
  parameter int ROUNDS  = 64,
  parameter int ROUND_W = 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               abort_in,
  msg_schedule_gen_if.master bus,
  output logic [1:0]         state_out
`ifdef MSG_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_out
`endif
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("msg_schedule_gen: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > (2 ** ROUND_W)) begin : g_bad_rounds
      $error("msg_schedule_gen: ROUNDS must be in 16..2**ROUND_W");
    end
  endgenerate

  // Rotate/shift amounts of the small sigma functions for each word width.
  localparam int S0_R1 = (WORD_W == 32) ? 7  : 1;
  localparam int S0_R2 = (WORD_W == 32) ? 18 : 8;
  localparam int S0_SH = (WORD_W == 32) ? 3  : 7;
  localparam int S1_R1 = (WORD_W == 32) ? 17 : 19;
  localparam int S1_R2 = (WORD_W == 32) ? 19 : 61;
  localparam int S1_SH = (WORD_W == 32) ? 10 : 6;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int                n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q [16];
  logic [ROUND_W-1:0] round_q;

  logic               w_valid;
  logic               last;
  logic               w_xfer;
  logic               blk_rdy;
  logic               blk_acc;
  logic               load;
  logic               shift;
  logic               clear;
  logic [WORD_W-1:0]  sig0;
  logic [WORD_W-1:0]  sig1;
  logic [WORD_W-1:0]  next_w;

  // shreg_q holds W[t..t+15]; next_w is W[t+16] from the standard recurrence.
  assign sig0   = rotr(shreg_q[1], S0_R1) ^ rotr(shreg_q[1], S0_R2) ^ (shreg_q[1] >> S0_SH);
  assign sig1   = rotr(shreg_q[14], S1_R1) ^ rotr(shreg_q[14], S1_R2) ^ (shreg_q[14] >> S1_SH);
  assign next_w = sig1 + shreg_q[9] + sig0 + shreg_q[0];

  assign w_valid = (state_q == ST_RUN);
  assign last    = w_valid && (round_q == LAST_ROUND);
  assign w_xfer  = w_valid && bus.w_ready_in;

  // Ready in RUN only when the last word leaves this very cycle: this is the
  // intentional comb path w_ready_in -> blk_ready_out that removes the bubble.
  assign blk_rdy = RST && !abort_in &&
                   ((state_q == ST_IDLE) || (last && bus.w_ready_in));
  assign blk_acc = bus.blk_valid_in && blk_rdy;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    if (abort_in) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_acc) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            shift = 1'b1;
            if (last) begin
              if (blk_acc) load    = 1'b1;
              else         state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || clear) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      for (int i = 0; i < 16; i++) shreg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        round_q <= '0;
        for (int i = 0; i < 16; i++) shreg_q[i] <= bus.blk_in[(16-i)*WORD_W-1 -: WORD_W];
      end else if (shift) begin
        round_q <= round_q + ROUND_W'(1);
        for (int i = 0; i < 15; i++) shreg_q[i] <= shreg_q[i+1];
        shreg_q[15] <= next_w;
      end
    end
  end

  assign bus.blk_ready_out = blk_rdy;
  assign bus.w_valid_out   = w_valid;
  assign bus.w_out         = shreg_q[0];
  assign bus.round_out     = round_q;
  assign bus.last_out      = last;
  assign state_out         = state_q;

`ifdef MSG_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Survives abort on purpose: it measures back-pressure since reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_q <= '0;
    end else if (w_valid && !bus.w_ready_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
